// File: rtl/isa_decode_mc_pkg.sv
// Shared constants and types for the ISA decoder with multi-channel trigger sequencers.
// Offsets are relative to the decoder's BASE_ADDR window.
package isa_decode_mc_pkg;

  localparam int TX_W = 64;

  localparam logic [31:0] OFF_TRIG   = 32'h0000_1000;
  localparam logic [31:0] OFF_STEP   = 32'h0000_1004;
  localparam logic [31:0] OFF_WCLR   = 32'h0000_1FFC;
  localparam logic [31:0] OFF_WADD   = 32'h0000_2000;
  localparam logic [31:0] OFF_FMR    = 32'h0000_4000;
  localparam logic [31:0] CH_STRIDE  = 32'h0000_0010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } seq_state_e;

  // 32-bit add that clamps at all-ones instead of wrapping.
  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/isa_trig_seq.sv
// One trigger channel: emits count pulses spaced step idle cycles apart.
// A start request always aborts the current sequence and restarts it.
module isa_trig_seq
  import isa_decode_mc_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] count_i,
  input  logic        step_we_i,
  input  logic [31:0] step_i,
  output logic        trig_o,
  output seq_state_e  state_o
);

  seq_state_e  state_q;
  logic [31:0] rem_q;   // pulses left, including the one in progress
  logic [31:0] gap_q;   // idle cycles left in the current gap
  logic [31:0] step_q;
  logic        trig_q;

  // Sequencer FSM with registered pulse output; the gap length is latched on PULSE exit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      gap_q   <= '0;
      step_q  <= '0;
      trig_q  <= 1'b0;
    end else begin
      if (step_we_i) step_q <= step_i;
      if (start_i) begin
        rem_q <= count_i;
        gap_q <= '0;
        if (count_i == '0) begin
          state_q <= ST_IDLE;
          trig_q  <= 1'b0;
        end else begin
          state_q <= ST_PULSE;
          trig_q  <= 1'b1;
        end
      end else begin
        case (state_q)
          ST_PULSE: begin
            if (rem_q <= 32'd1) begin
              rem_q   <= '0;
              state_q <= ST_IDLE;
              trig_q  <= 1'b0;
            end else begin
              rem_q <= rem_q - 32'd1;
              if (step_q != '0) begin
                gap_q   <= step_q;
                state_q <= ST_GAP;
                trig_q  <= 1'b0;
              end else begin
                state_q <= ST_PULSE;
                trig_q  <= 1'b1;
              end
            end
          end
          ST_GAP: begin
            if (gap_q <= 32'd1) begin
              gap_q   <= '0;
              state_q <= ST_PULSE;
              trig_q  <= 1'b1;
            end else begin
              gap_q <= gap_q - 32'd1;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            trig_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign trig_o  = trig_q;
  assign state_o = state_q;

endmodule

// File: rtl/isa_decode_mc.sv
// Decodes instruction beats in an address window into trigger-channel control,
// a saturating wait accumulator and a first-word-fall-through tx FIFO.
// Optional statistics counters are built when ISA_DECODE_MC_STATS_EN is defined.
// Handshake: a beat/word transfers on a clock edge where valid && ready are both high;
// valid must not depend on ready, and ready here only reflects FIFO space.
module isa_decode_mc
  import isa_decode_mc_pkg::*;
#(
  parameter int          NUM_CH    = 4,
  parameter int          TX_DEPTH  = 4,
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
  input  logic              I_clk,
  input  logic              I_rst,
  input  logic              I_isa_valid,
  output logic              O_isa_ready,
  input  logic [31:0]       I_isa_addr,
  input  logic [31:0]       I_isa_data,
  output logic [TX_W-1:0]   O_tx_data,
  output logic              O_tx_valid,
  input  logic              I_tx_ready,
  output logic [NUM_CH-1:0] O_trig,
  output logic [NUM_CH-1:0] O_trig_busy,
  output logic [31:0]       O_wait,
  output logic [31:0]       O_stat_decoded,
  output logic [15:0]       O_stat_unknown
);

  localparam int AW = $clog2(TX_DEPTH);

  logic [31:0]       off;
  logic              acc;
  logic [NUM_CH-1:0] trig_hit;
  logic [NUM_CH-1:0] step_hit;
  logic              wclr_hit, wadd_hit, fmr_hit;
  logic [31:0]       wait_q;

  logic [TX_W-1:0]   mem_q [TX_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       cnt_q;
  logic              fifo_full, push, pop;
  logic [TX_W-1:0]   push_word;

  assign off         = I_isa_addr - BASE_ADDR;
  assign fifo_full   = (cnt_q == (AW+1)'(TX_DEPTH));
  assign O_isa_ready = !fifo_full;
  assign acc         = I_isa_valid && O_isa_ready;

  assign wclr_hit = (off == OFF_WCLR);
  assign wadd_hit = (off == OFF_WADD);
  assign fmr_hit  = (off[31:12] == OFF_FMR[31:12]);

  genvar ch;
  generate
    for (ch = 0; ch < NUM_CH; ch++) begin : g_ch
      seq_state_e ch_state;
      assign trig_hit[ch] = (off == OFF_TRIG + 32'(ch) * CH_STRIDE);
      assign step_hit[ch] = (off == OFF_STEP + 32'(ch) * CH_STRIDE);
      isa_trig_seq u_seq (
        .clk_i     (I_clk),
        .rst_i     (I_rst),
        .start_i   (acc && trig_hit[ch]),
        .count_i   (I_isa_data),
        .step_we_i (acc && step_hit[ch]),
        .step_i    (I_isa_data),
        .trig_o    (O_trig[ch]),
        .state_o   (ch_state)
      );
      assign O_trig_busy[ch] = (ch_state != ST_IDLE);
    end
  endgenerate

  // Wait accumulator: clear wins only by address, the two ops are mutually exclusive.
  always_ff @(posedge I_clk) begin
    if (I_rst)                wait_q <= '0;
    else if (acc && wclr_hit) wait_q <= '0;
    else if (acc && wadd_hit) wait_q <= sat_add32(wait_q, I_isa_data);
  end
  assign O_wait = wait_q;

  // FMR snapshots the wait value before any update of this same beat.
  assign push      = acc && ((|trig_hit) || fmr_hit);
  assign pop       = O_tx_valid && I_tx_ready;
  assign push_word = (|trig_hit) ? {I_isa_addr, I_isa_data}
                                 : {I_isa_addr, I_isa_data[31:24], wait_q[23:0]};

  // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // FIFO storage; contents are don't-care until written, the head is masked when empty.
  always_ff @(posedge I_clk) begin
    if (push) mem_q[wr_ptr_q] <= push_word;
  end

  assign O_tx_valid = (cnt_q != '0);
  assign O_tx_data  = O_tx_valid ? mem_q[rd_ptr_q] : '0;

`ifdef ISA_DECODE_MC_STATS_EN
  logic        mapped;
  logic [31:0] stat_dec_q;
  logic [15:0] stat_unk_q;

  assign mapped = (|trig_hit) || (|step_hit) || wclr_hit || wadd_hit || fmr_hit;

  // Saturating counters of accepted mapped and unmapped beats.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      stat_dec_q <= '0;
      stat_unk_q <= '0;
    end else if (acc) begin
      if (mapped && stat_dec_q != 32'hFFFF_FFFF) stat_dec_q <= stat_dec_q + 32'd1;
      if (!mapped && stat_unk_q != 16'hFFFF)     stat_unk_q <= stat_unk_q + 16'd1;
    end
  end
  assign O_stat_decoded = stat_dec_q;
  assign O_stat_unknown = stat_unk_q;
`else
  assign O_stat_decoded = '0;
  assign O_stat_unknown = '0;
`endif

endmodule

// File: tb/tb_isa_decode_mc.sv
// Directed bench for isa_decode_mc with default parameters (NUM_CH=4, TX_DEPTH=4,
// BASE_ADDR=0x4000_0000). Inputs change and outputs are sampled 1 time unit after posedge.
module tb_isa_decode_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic        isa_valid;
  logic        isa_ready;
  logic [31:0] isa_addr;
  logic [31:0] isa_data;
  logic [63:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [3:0]  trig;
  logic [3:0]  trig_busy;
  logic [31:0] wait_o;
  logic [31:0] stat_dec;
  logic [15:0] stat_unk;

  int n_chk = 0;
  int n_err = 0;
  int exp_dec = 0;
  int exp_unk = 0;
  logic [63:0] exp_q[$];

  isa_decode_mc dut (
    .I_clk          (clk),
    .I_rst          (rst),
    .I_isa_valid    (isa_valid),
    .O_isa_ready    (isa_ready),
    .I_isa_addr     (isa_addr),
    .I_isa_data     (isa_data),
    .O_tx_data      (tx_data),
    .O_tx_valid     (tx_valid),
    .I_tx_ready     (tx_ready),
    .O_trig         (trig),
    .O_trig_busy    (trig_busy),
    .O_wait         (wait_o),
    .O_stat_decoded (stat_dec),
    .O_stat_unknown (stat_unk)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver: one instruction beat, accepted on the next edge once ready is high
  task automatic beat(input logic [31:0] addr, input logic [31:0] data, input bit mapped);
    int guard;
    guard = 0;
    while (!isa_ready && guard < 100) begin
      tick();
      guard++;
    end
    if (!isa_ready) chk("beat_ready_timeout", 64'(isa_ready), 64'd1);
    isa_valid = 1'b1;
    isa_addr  = addr;
    isa_data  = data;
    tick();
    isa_valid = 1'b0;
    if (mapped) exp_dec++;
    else        exp_unk++;
  endtask

  task automatic chk_stats(input string tag);
`ifdef ISA_DECODE_MC_STATS_EN
    chk({tag, "_dec"}, 64'(stat_dec), 64'(exp_dec));
    chk({tag, "_unk"}, 64'(stat_unk), 64'(exp_unk));
`else
    chk({tag, "_dec"}, 64'(stat_dec), 64'd0);
    chk({tag, "_unk"}, 64'(stat_unk), 64'd0);
`endif
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_trig"},  64'(trig), 64'd0);
    chk({tag, "_busy"},  64'(trig_busy), 64'd0);
    chk({tag, "_wait"},  64'(wait_o), 64'd0);
    chk({tag, "_txv"},   64'(tx_valid), 64'd0);
    chk({tag, "_txd"},   tx_data, 64'd0);
    chk({tag, "_ready"}, 64'(isa_ready), 64'd1);
    chk({tag, "_sdec"},  64'(stat_dec), 64'd0);
    chk({tag, "_sunk"},  64'(stat_unk), 64'd0);
  endtask

  initial begin
    int pulses;
    int late;
    rst       = 1'b1;
    isa_valid = 1'b0;
    isa_addr  = '0;
    isa_data  = '0;
    tx_ready  = 1'b1;
    tick();
    tick();
    chk_reset_state("rst");
    rst = 1'b0;
    tick();

    // ch1: step 2, count 3 -> pulses at t+1, t+4, t+7; busy drops at t+8
    beat(32'h4000_1014, 32'd2, 1'b1);
    beat(32'h4000_1010, 32'd3, 1'b1);
    chk("seq1_t1_trig", 64'(trig), 64'h2);
    chk("seq1_t1_busy", 64'(trig_busy), 64'h2);
    chk("seq1_tx_valid", 64'(tx_valid), 64'd1);
    chk("seq1_tx_data", tx_data, {32'h4000_1010, 32'd3});
    for (int i = 2; i <= 8; i++) begin
      tick();
      chk($sformatf("seq1_t%0d_trig", i), 64'(trig[1]), 64'((i == 4 || i == 7) ? 1 : 0));
      chk($sformatf("seq1_t%0d_busy", i), 64'(trig_busy[1]), 64'((i == 8) ? 0 : 1));
    end
    chk("seq1_fifo_drained", 64'(tx_valid), 64'd0);

    // saturating wait accumulator and FMR snapshot
    beat(32'h4000_2000, 32'hFFFF_FFF0, 1'b1);
    chk("wadd1", 64'(wait_o), 64'hFFFF_FFF0);
    beat(32'h4000_2000, 32'h0000_0020, 1'b1);
    chk("wadd_sat", 64'(wait_o), 64'hFFFF_FFFF);
    beat(32'h4000_4010, 32'hAB00_0000, 1'b1);
    chk("fmr_valid", 64'(tx_valid), 64'd1);
    chk("fmr_data", tx_data, {32'h4000_4010, 8'hAB, 24'hFF_FFFF});
    beat(32'h4000_1FFC, 32'h1234_5678, 1'b1);
    chk("wclr", 64'(wait_o), 64'd0);
    beat(32'h4000_2000, 32'd5, 1'b1);
    chk("wadd5", 64'(wait_o), 64'd5);

    // FIFO backpressure: 4 words fill it, one pop reopens it, order preserved
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      beat(32'h4000_4000 + 32'(i), {8'(i + 1), 24'h0}, 1'b1);
      exp_q.push_back({32'h4000_4000 + 32'(i), 8'(i + 1), 24'd5});
      chk($sformatf("fill%0d_ready", i), 64'(isa_ready), 64'((i == 3) ? 0 : 1));
    end
    chk("full_head", tx_data, exp_q[0]);
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    void'(exp_q.pop_front());
    chk("pop_reopen_ready", 64'(isa_ready), 64'd1);
    beat(32'h4000_4004, 32'h0500_0000, 1'b1);
    exp_q.push_back({32'h4000_4004, 8'h05, 24'd5});
    chk("refill_ready", 64'(isa_ready), 64'd0);
    tx_ready = 1'b1;
    while (exp_q.size() > 0) begin
      chk("drain_valid", 64'(tx_valid), 64'd1);
      chk("drain_data", tx_data, exp_q[0]);
      void'(exp_q.pop_front());
      tick();
    end
    chk("drain_empty", 64'(tx_valid), 64'd0);

    // ch0 step 0, count 5; retrigger with count 1 during the 2nd pulse -> 3 pulses
    beat(32'h4000_1004, 32'd0, 1'b1);
    beat(32'h4000_1000, 32'd5, 1'b1);
    pulses = 0;
    pulses += int'(trig[0]);
    tick();
    pulses += int'(trig[0]);
    beat(32'h4000_1000, 32'd1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      pulses += int'(trig[0]);
      tick();
    end
    chk("retrig_pulses", 64'(pulses), 64'd3);
    chk("retrig_idle", 64'(trig_busy), 64'd0);

    // unmapped offset and out-of-range channel: only the unknown counter moves
    tick();
    tick();
    beat(32'h4000_3000, 32'hDEAD_BEEF, 1'b0);
    beat(32'h4000_1040, 32'd7, 1'b0);
    chk("unk_trig", 64'(trig), 64'd0);
    chk("unk_busy", 64'(trig_busy), 64'd0);
    chk("unk_wait", 64'(wait_o), 64'd5);
    chk("unk_txv", 64'(tx_valid), 64'd0);
    chk_stats("unk_stats");

    // reset while ch2 is in its gap
    beat(32'h4000_1024, 32'd3, 1'b1);
    beat(32'h4000_1020, 32'd4, 1'b1);
    chk("rgap_t1_trig", 64'(trig[2]), 64'd1);
    tick();
    chk("rgap_t2_gap", 64'({trig[2], trig_busy[2]}), 64'b01);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_state("rgap");
    late = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      late += int'(|trig);
    end
    chk("rgap_no_pulse", 64'(late), 64'd0);
    chk("rgap_busy", 64'(trig_busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
